lsu_initiator: RTL and testbench

Load/store initiator between the single-cycle RV32I core and a handshaked, word-organised data memory bus. It accepts one core load/store (address, write data, `DMCtrl` access mode), converts it into word-aligned bus beats with byte enables, waits for each response, and returns the extracted, sign/zero-extended load result with a one-cycle `done` pulse. The core stalls on `busy`. Misaligned accesses are either split into two beats or rejected, depending on configuration.

---
 rtl/lsu_initiator.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_lsu_initiator.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_initiator.sv
// Load/store initiator: turns one core access into word-aligned bus beats and returns the extended load result.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (split misaligned accesses into two beats instead of rejecting them).
module lsu_initiator #(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] DataRd,
    output logic        done,
    output logic        busy,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  dbg_state
);

    // Bus handshake: a beat is presented with mem_req and held unchanged until the cycle
    // mem_gnt=1; its single response (load data or store ack) is the first mem_rvalid seen
    // in a later cycle while waiting in RSP0/RSP1.

    localparam int CW = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ0 = 3'd1,
        S_RSP0 = 3'd2,
        S_DONE = 3'd5
`ifdef LSU_MISALIGN_SPLIT_EN
        ,
        S_REQ1 = 3'd3,
        S_RSP1 = 3'd4
`endif
    } state_t;

    function automatic logic ctrl_valid(input logic [2:0] c);
        return (c == 3'b000) || (c == 3'b001) || (c == 3'b010) ||
               (c == 3'b100) || (c == 3'b101);
    endfunction

    function automatic logic [3:0] size_of(input logic [2:0] c);
        case (c[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            default: return 4'd4;
        endcase
    endfunction

    // Lanes over two consecutive words: [3:0] first beat, [7:4] second beat.
    function automatic logic [7:0] lanes_of(input logic [2:0] c, input logic [1:0] o);
        logic [7:0] base;
        case (c[1:0])
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << o;
    endfunction

    function automatic logic mis_of(input logic [2:0] c, input logic [1:0] o);
        return ({2'b00, o} + size_of(c)) > 4'd4;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    function automatic logic [31:0] load_result(input logic [2:0]  c,
                                                input logic [1:0]  o,
                                                input logic [7:0]  lanes,
                                                input logic [31:0] r0,
                                                input logic [31:0] r1);
        logic [63:0] w;
        w = {r1 & lane_mask(lanes[7:4]), r0 & lane_mask(lanes[3:0])} >> {o, 3'b000};
        case (c)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w[31:0];
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic          we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [29:0]   addr_hi_q, addr_hi_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata0_q, rdata0_d;
    logic          mis_q;
    logic [31:0]   wdata1_q;
`endif

    logic [31:0] data_rd_d, mem_addr_d, mem_wdata_d;
    logic [3:0]  mem_be_d;
    logic        done_d, busy_d, misalign_d, bus_err_d, mem_req_d, mem_we_d;

    logic [7:0]  lanes_in, lanes_q;
    logic        mis_in;
    logic [31:0] wdata0_in;

    assign lanes_in  = lanes_of(DMCtrl, Address[1:0]);
    assign mis_in    = mis_of(DMCtrl, Address[1:0]);
    assign wdata0_in = DataWr << {Address[1:0], 3'b000};
    assign lanes_q   = lanes_of(ctrl_q, off_q);
`ifdef LSU_MISALIGN_SPLIT_EN
    assign mis_q     = mis_of(ctrl_q, off_q);
    // Bytes that spill past the first word; a shift by 32 yields zero for offset 0.
    assign wdata1_q  = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
`endif

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        ctrl_d      = ctrl_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        addr_hi_d   = addr_hi_q;
        wdata_d     = wdata_q;
        rdata0_d    = rdata0_q;
`endif
        data_rd_d   = 32'h0;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_be_d    = mem_be;
        mem_wdata_d = mem_wdata;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    off_d  = Address[1:0];
                    ctrl_d = DMCtrl;
                    we_d   = DMWr;
`ifdef LSU_MISALIGN_SPLIT_EN
                    addr_hi_d = Address[31:2];
                    wdata_d   = DataWr;
`endif
                    if (!ctrl_valid(DMCtrl)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
`ifndef LSU_MISALIGN_SPLIT_EN
                    else if (mis_in) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end
`endif
                    else begin
                        state_d     = S_REQ0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = DMWr;
                        mem_addr_d  = {Address[31:2], 2'b00};
                        mem_be_d    = lanes_in[3:0];
                        mem_wdata_d = wdata0_in;
                    end
                end
            end
            S_REQ0: begin
                if (mem_gnt) begin
                    state_d     = S_RSP0;
                    cnt_d       = '0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_be_d    = 4'h0;
                    mem_wdata_d = 32'h0;
                end
            end
            S_RSP0: begin
                if (mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    rdata0_d = mem_rdata;
                    if (mis_q) begin
                        state_d     = S_REQ1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = we_q;
                        mem_addr_d  = {addr_hi_q + 30'd1, 2'b00};
                        mem_be_d    = lanes_q[7:4];
                        mem_wdata_d = wdata1_q;
                    end else
`endif
                    begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        data_rd_d = we_q ? 32'h0 :
                                    load_result(ctrl_q, off_q, lanes_q, mem_rdata, 32'h0);
                    end
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_REQ1: begin
                if (mem_gnt) begin
                    state_d     = S_RSP1;
                    cnt_d       = '0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_be_d    = 4'h0;
                    mem_wdata_d = 32'h0;
                end
            end
            S_RSP1: begin
                if (mem_rvalid) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    data_rd_d = we_q ? 32'h0 :
                                load_result(ctrl_q, off_q, lanes_q, rdata0_q, mem_rdata);
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            off_q        <= 2'b00;
            ctrl_q       <= 3'b000;
            we_q         <= 1'b0;
            cnt_q        <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            addr_hi_q    <= 30'h0;
            wdata_q      <= 32'h0;
            rdata0_q     <= 32'h0;
`endif
            DataRd       <= 32'h0;
            done         <= 1'b0;
            busy         <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_be       <= 4'h0;
            mem_wdata    <= 32'h0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            ctrl_q       <= ctrl_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            addr_hi_q    <= addr_hi_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
`endif
            DataRd       <= data_rd_d;
            done         <= done_d;
            busy         <= busy_d;
            misalign_err <= misalign_d;
            bus_err      <= bus_err_d;
            mem_req      <= mem_req_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_be       <= mem_be_d;
            mem_wdata    <= mem_wdata_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_initiator.sv
// Directed bench for lsu_initiator: a cycle-accurate bus responder driven from tasks, one task per scenario.
module tb_lsu_initiator;

    logic        clk = 1'b0;
    logic        rst, req, DMWr, mem_gnt, mem_rvalid;
    logic [31:0] Address, DataWr, mem_rdata;
    logic [2:0]  DMCtrl;
    logic [31:0] DataRd, mem_addr, mem_wdata;
    logic        done, busy, misalign_err, bus_err, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    lsu_initiator #(.RESP_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req(req), .Address(Address), .DataWr(DataWr),
        .DMWr(DMWr), .DMCtrl(DMCtrl), .DataRd(DataRd), .done(done), .busy(busy),
        .misalign_err(misalign_err), .bus_err(bus_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    logic [31:0] mem [logic [31:0]];
    int n_cmp = 0;
    int n_bad = 0;

    // Results of the most recent run_access call.
    int          r_done_cyc, r_nbeats, r_unstable;
    logic [31:0] r_rd;
    logic        r_merr, r_berr, r_req_seen;
    logic [31:0] b_addr [2];
    logic [31:0] b_wdata [2];
    logic [3:0]  b_be [2];
    logic        b_we [2];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Cycle 0 is the cycle req is first presented; inputs change only on negedges.
    task automatic run_access(input logic [31:0] a, input logic [31:0] d, input logic we,
                              input logic [2:0] ctrl, input int gnt_wait,
                              input bit rsp_en, input bit stray);
        int waited;
        bit pend;
        logic [31:0] pend_addr;
        waited = 0; pend = 0; pend_addr = 32'h0;
        r_done_cyc = -1; r_nbeats = 0; r_unstable = 0; r_rd = 32'hX;
        r_merr = 1'bX; r_berr = 1'bX; r_req_seen = 1'b0;
        @(negedge clk);
        req = 1'b1; Address = a; DataWr = d; DMWr = we; DMCtrl = ctrl;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
            if (done) begin
                r_done_cyc = cyc; r_rd = DataRd; r_merr = misalign_err; r_berr = bus_err;
                req = 1'b0;
                break;
            end
            if (pend && rsp_en) begin
                mem_rvalid = 1'b1;
                mem_rdata = mem_read(pend_addr);
                pend = 0;
            end else if (mem_req) begin
                r_req_seen = 1'b1;
                if (waited == 0 && r_nbeats < 2) begin
                    b_addr[r_nbeats] = mem_addr; b_be[r_nbeats] = mem_be;
                    b_wdata[r_nbeats] = mem_wdata; b_we[r_nbeats] = mem_we;
                end else if (r_nbeats < 2 && (mem_addr !== b_addr[r_nbeats] ||
                         mem_be !== b_be[r_nbeats] || mem_wdata !== b_wdata[r_nbeats])) begin
                    r_unstable++;
                end
                if (waited == gnt_wait) begin
                    mem_gnt = 1'b1; pend = 1; pend_addr = mem_addr;
                    r_nbeats++; waited = 0;
                end else begin
                    waited++;
                    if (stray) begin
                        mem_rvalid = 1'b1;
                        mem_rdata = 32'hA5A5_A5A5;
                    end
                end
            end
        end
        req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; Address = 32'h0; DataWr = 32'h0; DMWr = 1'b0;
        DMCtrl = 3'b000; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({DataRd, done, busy, misalign_err, bus_err} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_core_outs: got %h expected 0", {DataRd, done, busy, misalign_err, bus_err});
        end
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== 70'h0) begin
            n_bad++;
            $display("FAIL reset_bus_outs: got %h expected 0", {mem_req, mem_we, mem_addr, mem_be, mem_wdata});
        end
        rst = 1'b0;
    endtask

    task automatic test_load_byte();
        mem[32'h100] = 32'h80FF_1234;
        run_access(32'h103, 32'h0, 1'b0, 3'b000, 0, 1, 0);
        n_cmp++;
        if (r_done_cyc != 3) begin n_bad++; $display("FAIL lb_done_cycle: got %0d expected 3", r_done_cyc); end
        n_cmp++;
        if (b_addr[0] !== 32'h100 || b_be[0] !== 4'b1000 || b_we[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL lb_beat: got addr %h be %b we %b expected 00000100 1000 0", b_addr[0], b_be[0], b_we[0]);
        end
        n_cmp++;
        if (r_rd !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data: got %h expected ffffff80", r_rd); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL lb_pulse_end: got done %b busy %b expected 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [2:0]  ctrls [4];
        logic [31:0] exps  [4];
        addrs = '{32'h101, 32'h102, 32'h102, 32'h100};
        ctrls = '{3'b100, 3'b001, 3'b101, 3'b010};
        exps  = '{32'h0000_0012, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_1234};
        for (int i = 0; i < 4; i++) begin
            run_access(addrs[i], 32'h0, 1'b0, ctrls[i], 0, 1, 0);
            n_cmp++;
            if (r_rd !== exps[i] || r_done_cyc != 3) begin
                n_bad++;
                $display("FAIL b2b_load%0d: got %h at cycle %0d expected %h at cycle 3", i, r_rd, r_done_cyc, exps[i]);
            end
        end
    endtask

    task automatic test_store();
        run_access(32'h202, 32'h0000_BEEF, 1'b1, 3'b001, 0, 1, 0);
        n_cmp++;
        if (b_addr[0] !== 32'h200 || b_be[0] !== 4'b1100 || b_wdata[0] !== 32'hBEEF_0000 || b_we[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL sh_beat: got %h %b %h %b expected 00000200 1100 beef0000 1", b_addr[0], b_be[0], b_wdata[0], b_we[0]);
        end
        n_cmp++;
        if (r_rd !== 32'h0 || r_done_cyc != 3) begin
            n_bad++;
            $display("FAIL sh_done: got data %h cycle %0d expected 0 cycle 3", r_rd, r_done_cyc);
        end
        run_access(32'h201, 32'h0000_00A5, 1'b1, 3'b000, 0, 1, 0);
        n_cmp++;
        if (b_be[0] !== 4'b0010 || b_wdata[0] !== 32'h0000_A500) begin
            n_bad++;
            $display("FAIL sb_beat: got be %b wdata %h expected 0010 0000a500", b_be[0], b_wdata[0]);
        end
    endtask

    task automatic test_misalign();
        mem[32'h100] = 32'h4433_2211;
        mem[32'h104] = 32'h8877_6655;
        run_access(32'h101, 32'h0, 1'b0, 3'b010, 0, 1, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
        n_cmp++;
        if (r_nbeats != 2 || b_addr[0] !== 32'h100 || b_be[0] !== 4'b1110 ||
            b_addr[1] !== 32'h104 || b_be[1] !== 4'b0001) begin
            n_bad++;
            $display("FAIL split_beats: got %0d beats %h/%b %h/%b expected 2 00000100/1110 00000104/0001",
                     r_nbeats, b_addr[0], b_be[0], b_addr[1], b_be[1]);
        end
        n_cmp++;
        if (r_rd !== 32'h5544_3322 || r_done_cyc != 5 || r_merr !== 1'b0) begin
            n_bad++;
            $display("FAIL split_load: got %h cycle %0d merr %b expected 55443322 cycle 5 merr 0", r_rd, r_done_cyc, r_merr);
        end
        run_access(32'hFFFF_FFFF, 32'h0000_BEEF, 1'b1, 3'b001, 0, 1, 0);
        n_cmp++;
        if (b_addr[0] !== 32'hFFFF_FFFC || b_be[0] !== 4'b1000 || b_wdata[0] !== 32'hEF00_0000 ||
            b_addr[1] !== 32'h0 || b_be[1] !== 4'b0001 || b_wdata[1] !== 32'h0000_00BE) begin
            n_bad++;
            $display("FAIL split_wrap: got %h/%b/%h %h/%b/%h expected fffffffc/1000/ef000000 00000000/0001/000000be",
                     b_addr[0], b_be[0], b_wdata[0], b_addr[1], b_be[1], b_wdata[1]);
        end
`else
        n_cmp++;
        if (r_merr !== 1'b1 || r_rd !== 32'h0 || r_done_cyc != 1) begin
            n_bad++;
            $display("FAIL misalign_reject: got merr %b data %h cycle %0d expected 1 0 cycle 1", r_merr, r_rd, r_done_cyc);
        end
        n_cmp++;
        if (r_req_seen !== 1'b0) begin n_bad++; $display("FAIL misalign_no_bus: got mem_req seen %b expected 0", r_req_seen); end
`endif
    endtask

    task automatic test_invalid_ctrl();
        run_access(32'h100, 32'h0, 1'b0, 3'b011, 0, 1, 0);
        n_cmp++;
        if (r_done_cyc != 1 || r_rd !== 32'h0 || r_req_seen !== 1'b0 || r_merr !== 1'b0 || r_berr !== 1'b0) begin
            n_bad++;
            $display("FAIL invalid_ctrl: got cycle %0d data %h req %b merr %b berr %b expected 1 0 0 0 0",
                     r_done_cyc, r_rd, r_req_seen, r_merr, r_berr);
        end
    endtask

    task automatic test_gnt_wait();
        run_access(32'h300, 32'hCAFE_F00D, 1'b1, 3'b010, 3, 1, 1);
        n_cmp++;
        if (r_done_cyc != 6 || r_unstable != 0) begin
            n_bad++;
            $display("FAIL gnt_wait_store: got cycle %0d unstable %0d expected 6 0", r_done_cyc, r_unstable);
        end
        n_cmp++;
        if (b_wdata[0] !== 32'hCAFE_F00D || b_be[0] !== 4'b1111) begin
            n_bad++;
            $display("FAIL gnt_wait_beat: got %h %b expected cafef00d 1111", b_wdata[0], b_be[0]);
        end
        run_access(32'h100, 32'h0, 1'b0, 3'b010, 3, 1, 1);
        n_cmp++;
        if (r_rd !== 32'h4433_2211 || r_done_cyc != 6) begin
            n_bad++;
            $display("FAIL gnt_wait_load: got %h cycle %0d expected 44332211 cycle 6", r_rd, r_done_cyc);
        end
    endtask

    task automatic test_timeout();
        run_access(32'h100, 32'h0, 1'b0, 3'b010, 0, 0, 0);
        n_cmp++;
        if (r_berr !== 1'b1 || r_rd !== 32'h0 || r_done_cyc < 6 || r_done_cyc > 7) begin
            n_bad++;
            $display("FAIL timeout: got berr %b data %h cycle %0d expected 1 0 cycle 6..7", r_berr, r_rd, r_done_cyc);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_idle: got busy %b done %b expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        @(negedge clk);
        req = 1'b1; Address = 32'h100; DataWr = 32'h0; DMWr = 1'b0; DMCtrl = 3'b010;
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_req: got mem_req %b expected 1", mem_req); end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; rst = 1'b1; req = 1'b0;
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        n_cmp++;
        if ({DataRd, done, busy, misalign_err, bus_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== 106'h0) begin
            n_bad++;
            $display("FAIL rstmid_outs: got %h expected 0",
                     {DataRd, done, busy, misalign_err, bus_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata});
        end
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (done || busy) seen_done = 1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done: got activity %b expected 0", seen_done); end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_back_to_back();
        test_store();
        test_misalign();
        test_invalid_ctrl();
        test_gnt_wait();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
